// File: rtl/nmea_rmc_parser_if.sv
// Byte stream in, decoded RMC time/fix and result pulses out.
interface nmea_rmc_parser_if;
  logic [7:0] in_data;
  logic       in_flag;
  logic [7:0] utc_hour;
  logic [7:0] utc_min;
  logic [7:0] utc_sec;
  logic       fix_ok;
  logic       op_flag;
  logic       err_flag;

  modport master (
    output in_data, in_flag,
    input  utc_hour, utc_min, utc_sec, fix_ok, op_flag, err_flag
  );

  modport slave (
    input  in_data, in_flag,
    output utc_hour, utc_min, utc_sec, fix_ok, op_flag, err_flag
  );
endinterface

// File: rtl/nmea_rmc_parser.sv
// NMEA RMC sentence parser: extracts UTC hh/mm/ss and fix status,
// verifies the XOR checksum and pulses op_flag / err_flag per sentence.
module nmea_rmc_parser #(
  parameter logic [7:0] MAX_LEN = 8'd82
) (
  input  logic             clk,
  input  logic             rst_n,
  nmea_rmc_parser_if.slave bus
);

  typedef enum logic [2:0] {IDLE, HDR, FIELD, CKS_HI, CKS_LO} state_e;

  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_COMMA  = 8'h2C;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_R      = 8'h52;
  localparam logic [7:0] CH_M      = 8'h4D;
  localparam logic [7:0] CH_C      = 8'h43;
  localparam logic [7:0] CH_A      = 8'h41;

  state_e     state_q, state_d;
  logic [7:0] len_q, len_d;
  logic [7:0] cks_q, cks_d;
  logic [3:0] fidx_q, fidx_d;
  logic [2:0] pos_q, pos_d;
  logic [7:0] sh_hh_q, sh_hh_d, sh_mm_q, sh_mm_d, sh_ss_q, sh_ss_d;
  logic       sh_fix_q, sh_fix_d;
  logic       bad_q, bad_d;
  logic [3:0] rx_hi_q, rx_hi_d;
  logic [7:0] utc_hour_q, utc_hour_d, utc_min_q, utc_min_d, utc_sec_q, utc_sec_d;
  logic       fix_ok_q, fix_ok_d;
  logic       op_flag_q, op_flag_d;
  logic       err_flag_q, err_flag_d;

  logic [7:0] b;
  logic       is_digit, is_hex, done, f1_short;
  logic [3:0] hex_val;
  logic [7:0] len_inc;

  // Character classification and saturating length increment
  always_comb begin
    b        = bus.in_data;
    is_digit = (b >= 8'h30) && (b <= 8'h39);
    is_hex   = is_digit || ((b >= 8'h41) && (b <= 8'h46));
    hex_val  = is_digit ? 4'(b - 8'h30) : 4'(b - 8'h37);
    len_inc  = (len_q >= MAX_LEN) ? len_q : len_q + 8'd1;
    f1_short = (fidx_q == 4'd1) && (pos_q < 3'd6);
  end

  // Next-state and output logic
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cks_d      = cks_q;
    fidx_d     = fidx_q;
    pos_d      = pos_q;
    sh_hh_d    = sh_hh_q;
    sh_mm_d    = sh_mm_q;
    sh_ss_d    = sh_ss_q;
    sh_fix_d   = sh_fix_q;
    bad_d      = bad_q;
    rx_hi_d    = rx_hi_q;
    utc_hour_d = utc_hour_q;
    utc_min_d  = utc_min_q;
    utc_sec_d  = utc_sec_q;
    fix_ok_d   = fix_ok_q;
    op_flag_d  = 1'b0;
    err_flag_d = 1'b0;
    done       = 1'b0;

    if (bus.in_flag) begin
      if (b == CH_DOLLAR) begin
        state_d  = HDR;
        len_d    = 8'd1;
        cks_d    = 8'd0;
        fidx_d   = 4'd0;
        pos_d    = 3'd0;
        bad_d    = 1'b0;
        rx_hi_d  = 4'd0;
        sh_hh_d  = 8'd0;
        sh_mm_d  = 8'd0;
        sh_ss_d  = 8'd0;
        sh_fix_d = 1'b0;
      end else begin
        if (state_q != IDLE) len_d = len_inc;
        case (state_q)
          IDLE: ;
          HDR: begin
            cks_d = cks_q ^ b;
            pos_d = pos_q + 3'd1;
            case (pos_q)
              3'd0, 3'd1: ;
              3'd2: if (b != CH_R) state_d = IDLE;
              3'd3: if (b != CH_M) state_d = IDLE;
              3'd4: if (b != CH_C) state_d = IDLE;
              default: begin
                if (b == CH_COMMA) begin
                  state_d = FIELD;
                  fidx_d  = 4'd1;
                  pos_d   = 3'd0;
                end else begin
                  state_d = IDLE;
                end
              end
            endcase
          end
          FIELD: begin
            if (b == CH_STAR) begin
              state_d = CKS_HI;
              if (f1_short) bad_d = 1'b1;
            end else begin
              cks_d = cks_q ^ b;
              if (b == CH_COMMA) begin
                if (f1_short) bad_d = 1'b1;
                fidx_d = (fidx_q == 4'd15) ? fidx_q : fidx_q + 4'd1;
                pos_d  = 3'd0;
              end else begin
                if (f1_short) begin
                  if (!is_digit) bad_d = 1'b1;
                  case (pos_q)
                    3'd0:    sh_hh_d[7:4] = b[3:0];
                    3'd1:    sh_hh_d[3:0] = b[3:0];
                    3'd2:    sh_mm_d[7:4] = b[3:0];
                    3'd3:    sh_mm_d[3:0] = b[3:0];
                    3'd4:    sh_ss_d[7:4] = b[3:0];
                    default: sh_ss_d[3:0] = b[3:0];
                  endcase
                end
                if ((fidx_q == 4'd2) && (pos_q == 3'd0)) sh_fix_d = (b == CH_A);
                pos_d = (pos_q == 3'd7) ? pos_q : pos_q + 3'd1;
              end
            end
          end
          CKS_HI: begin
            if (is_hex) begin
              rx_hi_d = hex_val;
              state_d = CKS_LO;
            end else begin
              err_flag_d = 1'b1;
              state_d    = IDLE;
            end
          end
          CKS_LO: begin
            done    = 1'b1;
            state_d = IDLE;
            if (is_hex && ({rx_hi_q, hex_val} == cks_q) && !bad_q) begin
              op_flag_d  = 1'b1;
              utc_hour_d = sh_hh_q;
              utc_min_d  = sh_mm_q;
              utc_sec_d  = sh_ss_q;
              fix_ok_d   = sh_fix_q;
            end else begin
              err_flag_d = 1'b1;
            end
          end
          default: state_d = IDLE;
        endcase
        // Overlong sentence: abort once the byte count hits the limit
        if ((state_q != IDLE) && !done && (len_inc >= MAX_LEN)) begin
          err_flag_d = 1'b1;
          op_flag_d  = 1'b0;
          state_d    = IDLE;
        end
      end
    end
  end

  // State and data registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      len_q      <= 8'd0;
      cks_q      <= 8'd0;
      fidx_q     <= 4'd0;
      pos_q      <= 3'd0;
      sh_hh_q    <= 8'd0;
      sh_mm_q    <= 8'd0;
      sh_ss_q    <= 8'd0;
      sh_fix_q   <= 1'b0;
      bad_q      <= 1'b0;
      rx_hi_q    <= 4'd0;
      utc_hour_q <= 8'd0;
      utc_min_q  <= 8'd0;
      utc_sec_q  <= 8'd0;
      fix_ok_q   <= 1'b0;
      op_flag_q  <= 1'b0;
      err_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cks_q      <= cks_d;
      fidx_q     <= fidx_d;
      pos_q      <= pos_d;
      sh_hh_q    <= sh_hh_d;
      sh_mm_q    <= sh_mm_d;
      sh_ss_q    <= sh_ss_d;
      sh_fix_q   <= sh_fix_d;
      bad_q      <= bad_d;
      rx_hi_q    <= rx_hi_d;
      utc_hour_q <= utc_hour_d;
      utc_min_q  <= utc_min_d;
      utc_sec_q  <= utc_sec_d;
      fix_ok_q   <= fix_ok_d;
      op_flag_q  <= op_flag_d;
      err_flag_q <= err_flag_d;
    end
  end

  assign bus.utc_hour = utc_hour_q;
  assign bus.utc_min  = utc_min_q;
  assign bus.utc_sec  = utc_sec_q;
  assign bus.fix_ok   = fix_ok_q;
  assign bus.op_flag  = op_flag_q;
  assign bus.err_flag = err_flag_q;

endmodule
